gate_sweep_checker: RTL

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_sweep_checker.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Walks every input vector of a small combinational network. Each vector is
//   held on stim for max(SETTLE_CYCLES,1) cycles, and then dut_out is compared
//   against EXP_TABLE for one cycle. Mismatches are counted, and the lowest
//   failing vector is captured. The result (pass) is published in DONE.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            request a full sweep (sampled in IDLE only)
//   abort            stop a running sweep, keeping the partial results
//   stim[N_IN]       vector driven to the network; 0 when not sweeping
//   dut_out          network output under test
//   busy             high in DRIVE and SAMPLE
//   done             one-cycle pulse when a sweep completes
//   pass             last completed sweep had no mismatches
//   err_count        mismatch count of the current or last sweep
//   first_fail_valid a mismatch has been captured
//   first_fail_vec   lowest mismatching vector
//
// state  | meaning
// IDLE   | waiting for start; results held
// DRIVE  | stim=vec, settle down-counter running
// SAMPLE | compare dut_out with EXP_TABLE[vec], advance vec
// DONE   | done pulse, pass published
module gate_sweep_checker #(
  parameter int                 N_IN          = 3,
  parameter int                 SETTLE_CYCLES = 1,
  parameter logic [2**N_IN-1:0] EXP_TABLE     = 8'hC8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CW         = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_EFF - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [N_IN:0]   ERR_MAX     = (N_IN+1)'(2**N_IN);
  localparam logic [N_IN:0]   ERR_ONE     = (N_IN+1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q;
  logic [CW-1:0]   settle_q;
  logic            mismatch;
  logic            accept;

  assign accept   = start && !abort;
  assign mismatch = (dut_out != EXP_TABLE[vec_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    stim    = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        stim = vec_q;
        if (abort)                 state_d = IDLE;
        else if (settle_q == '0)   state_d = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        stim = vec_q;
        if (abort)                 state_d = IDLE;
        else if (vec_q == VEC_LAST) state_d = DONE;
        else                       state_d = DRIVE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The settle timer is a down-counter. Clearing it for a new vector
  // means loading the terminal distance, so that DRIVE lasts SETTLE_EFF cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q            <= '0;
      settle_q         <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      pass             <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            vec_q            <= '0;
            settle_q         <= SETTLE_LOAD;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            pass             <= 1'b0;
          end
        end
        DRIVE: begin
          if (!abort && settle_q != '0) settle_q <= settle_q - CW'(1);
        end
        SAMPLE: begin
          // An abort in this cycle still records the comparison.
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + ERR_ONE;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec_q;
            end
          end
          if (!abort && vec_q != VEC_LAST) begin
            vec_q    <= vec_q + N_IN'(1);
            settle_q <= SETTLE_LOAD;
          end
        end
        DONE: begin
          // err_count already includes the final SAMPLE.
          pass <= (err_count == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
